// File: rtl/pico_vga_pkg.sv
// Shared definitions for the VGA text console: FSM encoding, character
// constants, default geometry and a small byte-classification helper.
package pico_vga_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned ROWS_DEF   = 60;
  localparam int unsigned ADRS_W_DEF = 13;
  localparam int unsigned COL_W      = 7;
  localparam int unsigned ROW_W      = 6;
  localparam int unsigned DATA_W     = 8;

  localparam logic [DATA_W-1:0] CH_BS    = 8'h08;
  localparam logic [DATA_W-1:0] CH_LF    = 8'h0A;
  localparam logic [DATA_W-1:0] CH_FF    = 8'h0C;
  localparam logic [DATA_W-1:0] CH_CR    = 8'h0D;
  localparam logic [DATA_W-1:0] CH_BLANK = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_BLK,
    ST_CLEAR
  } state_t;

  // Printable ASCII range that lands in the frame buffer.
  function automatic logic is_printable(input logic [DATA_W-1:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cursor_ctr.sv
// Cursor counter for the text console.
// Keeps column, row and the linear buffer address side by side so no
// multiplier is needed. Commands are one-hot-ish with priority
// home > inc > newline > cr > bs. On the bottom row a wrap or newline
// keeps the row and rewinds lin to the start of that row; the caller
// scrolls the buffer.
//   clk, rst              clock, async active-high reset
//   inc/newline/cr/bs/home cursor commands
//   col, row, lin          cursor position and linear address
//   last_col_c, last_row_c cursor sits on the last column / bottom row
module vga_cursor_ctr
  import pico_vga_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned ADRS_W = ADRS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              newline,
  input  logic              cr,
  input  logic              bs,
  input  logic              home,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADRS_W-1:0] lin,
  output logic              last_col_c,
  output logic              last_row_c
);

  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [ADRS_W-1:0] COLS_A  = ADRS_W'(COLS);

  logic [ADRS_W-1:0] row_base;

  assign row_base   = lin - ADRS_W'(col);
  assign last_col_c = (col == COL_MAX);
  assign last_row_c = (row == ROW_MAX);

  // Cursor position update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      lin <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
      lin <= '0;
    end else if (inc) begin
      if (last_col_c) begin
        col <= '0;
        if (last_row_c) begin
          lin <= row_base;
        end else begin
          row <= row + 1'b1;
          lin <= lin + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        lin <= lin + 1'b1;
      end
    end else if (newline) begin
      col <= '0;
      if (last_row_c) begin
        lin <= row_base;
      end else begin
        row <= row + 1'b1;
        lin <= row_base + COLS_A;
      end
    end else if (cr) begin
      col <= '0;
      lin <= row_base;
    end else if (bs && (col != '0)) begin
      col <= col - 1'b1;
      lin <= lin - 1'b1;
    end
  end

endmodule

// File: rtl/vga_text_console.sv
// Text-terminal sequencer in front of the VGA character frame buffer.
// Takes a byte stream, prints at the cursor, handles LF/CR/BS/FF, scrolls
// by read-copy when output runs past the bottom row, and blanks the screen
// after reset or on request. Sole master of the buffer port.
//   cpu_clk, rst           clock, async active-high reset
//   in_valid/in_data       byte offered; accepted when in_valid & in_ready
//   in_ready, busy         console idle / not idle
//   clr_req                one-cycle clear-screen pulse
//   fb_adrs/fb_wdata/fb_we buffer address, write data, write strobe
//   fb_rdata               buffer read data, one cycle after fb_adrs
//   cur_col, cur_row       cursor position
module vga_text_console
  import pico_vga_pkg::*;
#(
  parameter int unsigned        COLS   = COLS_DEF,
  parameter int unsigned        ROWS   = ROWS_DEF,
  parameter int unsigned        ADRS_W = ADRS_W_DEF,
  parameter logic [DATA_W-1:0]  BLANK  = CH_BLANK
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clr_req,
  output logic [ADRS_W-1:0] fb_adrs,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              fb_we,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  localparam logic [ADRS_W-1:0] COLS_A = ADRS_W'(COLS);
  localparam logic [ADRS_W-1:0] LAST_A = ADRS_W'(COLS * ROWS - 1);

  state_t            state, next_state;
  logic [ADRS_W-1:0] src, src_n, dst, dst_n;
  logic [ADRS_W-1:0] adrs_q, adrs_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              fwd_q, fwd_d;
  logic              ready_q, ready_d;

  logic              inc, newline, cr, bs, home;
  logic [ADRS_W-1:0] lin;
  logic              last_col_c, last_row_c;
  logic              is_put, is_lf, wrap_bottom;

  vga_cursor_ctr #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADRS_W (ADRS_W)
  ) u_cursor (
    .clk        (cpu_clk),
    .rst        (rst),
    .inc        (inc),
    .newline    (newline),
    .cr         (cr),
    .bs         (bs),
    .home       (home),
    .col        (cur_col),
    .row        (cur_row),
    .lin        (lin),
    .last_col_c (last_col_c),
    .last_row_c (last_row_c)
  );

  assign is_put      = is_printable(in_data);
  assign is_lf       = (in_data == CH_LF);
  // Decoded from the byte, not from the cursor commands, to keep the path acyclic.
  assign wrap_bottom = last_row_c & ((is_put & last_col_c) | is_lf);

  // A pending clear request withdraws in_ready so the offered byte stays put.
  assign in_ready = ready_q & ~clr_req;
  assign busy     = ~in_ready;
  assign fb_adrs  = adrs_q;
  assign fb_we    = we_q;
  // Scroll copy: the word read one cycle earlier is forwarded straight to the write.
  assign fb_wdata = fwd_q ? fb_rdata : wdata_q;

  // State and buffer-port registers.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      src     <= '0;
      dst     <= '0;
      adrs_q  <= '0;
      wdata_q <= BLANK;
      we_q    <= 1'b0;
      fwd_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      src     <= src_n;
      dst     <= dst_n;
      adrs_q  <= adrs_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fwd_q   <= fwd_d;
      ready_q <= ready_d;
    end
  end

  // Next state, next buffer-port values and cursor commands.
  always_comb begin
    next_state = state;
    src_n      = src;
    dst_n      = dst;
    adrs_d     = adrs_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    fwd_d      = 1'b0;
    ready_d    = 1'b0;
    inc        = 1'b0;
    newline    = 1'b0;
    cr         = 1'b0;
    bs         = 1'b0;
    home       = 1'b0;

    case (state)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && clr_req) begin
          next_state = ST_CLEAR;
          dst_n      = '0;
          ready_d    = 1'b0;
        end else if (ready_q && in_valid) begin
          if (is_put) begin
            we_d       = 1'b1;
            adrs_d     = lin;
            wdata_d    = in_data;
            inc        = 1'b1;
            ready_d    = 1'b0;
            next_state = ST_PUT;
          end else if (is_lf) begin
            newline = 1'b1;
          end else if (in_data == CH_CR) begin
            cr = 1'b1;
          end else if (in_data == CH_BS) begin
            bs = 1'b1;
          end else if (in_data == CH_FF) begin
            next_state = ST_CLEAR;
            dst_n      = '0;
            ready_d    = 1'b0;
          end
          // Running off the bottom row goes straight to the scroll copy.
          if (wrap_bottom) begin
            next_state = ST_SCR_RD;
            src_n      = COLS_A;
            dst_n      = '0;
            ready_d    = 1'b0;
          end
        end
      end

      ST_PUT: begin
        ready_d    = 1'b1;
        next_state = ST_IDLE;
      end

      ST_SCR_RD: begin
        adrs_d     = src;
        next_state = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        adrs_d     = dst;
        we_d       = 1'b1;
        fwd_d      = 1'b1;
        src_n      = src + 1'b1;
        dst_n      = dst + 1'b1;
        next_state = (src == LAST_A) ? ST_SCR_BLK : ST_SCR_RD;
      end

      ST_SCR_BLK: begin
        adrs_d  = dst;
        wdata_d = BLANK;
        we_d    = 1'b1;
        dst_n   = dst + 1'b1;
        if (dst == LAST_A) begin
          dst_n      = '0;
          next_state = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        adrs_d  = dst;
        wdata_d = BLANK;
        we_d    = 1'b1;
        dst_n   = dst + 1'b1;
        if (dst == LAST_A) begin
          dst_n      = '0;
          home       = 1'b1;
          next_state = ST_IDLE;
        end
      end

      default: next_state = ST_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console on a 4x3 screen with a 1-cycle-read RAM.
module tb_vga_text_console;

  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 3;
  localparam int unsigned ADRS_W = 4;
  localparam int          N      = COLS * ROWS;

  logic              cpu_clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              clr_req;
  logic [ADRS_W-1:0] fb_adrs;
  logic [7:0]        fb_wdata;
  logic              fb_we;
  logic [7:0]        fb_rdata;
  logic [6:0]        cur_col;
  logic [5:0]        cur_row;
  logic              busy;

  logic [7:0] mem [N];
  int         wr_adrs[$];
  int         wr_data[$];
  int         bad_adrs = 0;
  int         checks   = 0;
  int         errors   = 0;

  always #5 cpu_clk = ~cpu_clk;

  vga_text_console #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADRS_W (ADRS_W)
  ) dut (
    .cpu_clk  (cpu_clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr_req  (clr_req),
    .fb_adrs  (fb_adrs),
    .fb_wdata (fb_wdata),
    .fb_we    (fb_we),
    .fb_rdata (fb_rdata),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  // Frame buffer model: synchronous write, registered read of the old data.
  always @(posedge cpu_clk) begin
    if (int'(fb_adrs) < N) begin
      fb_rdata <= mem[int'(fb_adrs)];
      if (fb_we) mem[int'(fb_adrs)] <= fb_wdata;
    end else begin
      fb_rdata <= 8'h00;
    end
  end

  // Write log, sampled mid-cycle.
  always @(negedge cpu_clk) begin
    if (fb_we) begin
      wr_adrs.push_back(int'(fb_adrs));
      wr_data.push_back(int'(fb_wdata));
      if (int'(fb_adrs) >= N) bad_adrs++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc, input string tag);
    int n = 0;
    while (!in_ready && n < max_cyc) begin
      @(negedge cpu_clk);
      n++;
    end
    check({tag, " ready"}, int'(in_ready), 1);
  endtask

  // Offer one byte; returns on the negedge after the accepting edge.
  task automatic put(input logic [7:0] b);
    wait_ready(200, "put");
    in_valid = 1'b1;
    in_data  = b;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, " col"}, int'(cur_col), col);
    check({tag, " row"}, int'(cur_row), row);
  endtask

  task automatic clear_log();
    wr_adrs.delete();
    wr_data.delete();
  endtask

  task automatic check_blank_clear(input string tag);
    check({tag, " nwr"}, wr_adrs.size(), N);
    for (int i = 0; i < N && i < wr_adrs.size(); i++) begin
      check({tag, " adr"}, wr_adrs[i], i);
      check({tag, " dat"}, wr_data[i], 32'h20);
    end
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr_req  = 1'b0;
    repeat (2) @(negedge cpu_clk);

    // 1: reset values, then a full blanking pass
    check("rst we", int'(fb_we), 0);
    check("rst adrs", int'(fb_adrs), 0);
    check("rst wdata", int'(fb_wdata), 32'h20);
    check("rst ready", int'(in_ready), 0);
    check("rst busy", int'(busy), 1);
    check_cursor("rst", 0, 0);
    rst = 1'b0;
    wait_ready(100, "init");
    check_blank_clear("init");
    check_cursor("init", 0, 0);

    // 2: two printable bytes, one-cycle write latency
    clear_log();
    put(8'h41);
    check("A we", int'(fb_we), 1);
    check("A adrs", int'(fb_adrs), 0);
    check("A wdata", int'(fb_wdata), 32'h41);
    check("A ready low", int'(in_ready), 0);
    check_cursor("A", 1, 0);
    @(negedge cpu_clk);
    check("A ready back", int'(in_ready), 1);
    check("A we off", int'(fb_we), 0);
    put(8'h42);
    check("B adrs", int'(fb_adrs), 1);
    check("B wdata", int'(fb_wdata), 32'h42);
    wait_ready(10, "B");
    check_cursor("AB", 2, 0);
    check("AB nwr", wr_adrs.size(), 2);

    // 3: FF clears, then 5 'X' wrap into row 1
    put(8'h0C);
    wait_ready(100, "ff");
    check_cursor("ff", 0, 0);
    clear_log();
    for (int i = 0; i < 5; i++) put(8'h58);
    wait_ready(10, "X");
    check("X nwr", wr_adrs.size(), 5);
    for (int i = 0; i < 5 && i < wr_adrs.size(); i++) begin
      check("X adr", wr_adrs[i], i);
      check("X dat", wr_data[i], 32'h58);
    end
    check_cursor("X", 1, 1);

    // 4: clear by request, fill with 'a'..'k', then 'l' at the last cell scrolls
    clr_req = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    clr_req = 1'b0;
    check("clr busy", int'(busy), 1);
    wait_ready(100, "clr");
    for (int i = 0; i < N - 1; i++) put(8'(8'h61 + i));
    wait_ready(10, "fill");
    check_cursor("fill", 3, 2);
    clear_log();
    put(8'h6C);
    check("l we", int'(fb_we), 1);
    check("l adrs", int'(fb_adrs), 11);
    check("l wdata", int'(fb_wdata), 32'h6C);
    check_cursor("l", 0, 2);
    n = 0;
    while (busy && n < 500) begin
      @(negedge cpu_clk);
      n++;
    end
    // write cycle of 'l' plus 2*COLS*(ROWS-1)+COLS scroll cycles
    check("scroll busy", n, 1 + 2 * 4 * 2 + 4);
    check("scroll nwr", wr_adrs.size(), 1 + 8 + 4);
    for (int i = 0; i < N; i++)
      check("scroll mem", int'(mem[i]), (i < 8) ? 32'h65 + i : 32'h20);

    // 5: control codes without writes
    put(8'h51);
    put(8'h52);
    wait_ready(10, "QR");
    clear_log();
    put(8'h08);
    check_cursor("bs2", 1, 2);
    put(8'h0D);
    check_cursor("cr", 0, 2);
    put(8'h08);
    check_cursor("bs0", 0, 2);
    put(8'h01);
    put(8'h7F);
    @(negedge cpu_clk);
    check_cursor("drop", 0, 2);
    check("ctl nwr", wr_adrs.size(), 0);
    put(8'h0A);
    wait_ready(100, "lf");
    check_cursor("lf", 0, 2);
    check("lf mem4", int'(mem[4]), 32'h51);
    check("lf mem5", int'(mem[5]), 32'h52);
    check("lf mem6", int'(mem[6]), 32'h20);
    check("lf mem8", int'(mem[8]), 32'h20);

    // 6: reset in the middle of a scroll
    put(8'h0A);
    repeat (5) @(negedge cpu_clk);
    rst = 1'b1;
    #1;
    check("mid rst we", int'(fb_we), 0);
    check("mid rst ready", int'(in_ready), 0);
    check_cursor("mid rst", 0, 0);
    @(negedge cpu_clk);
    clear_log();
    rst = 1'b0;
    wait_ready(100, "re");
    check_blank_clear("re");
    check_cursor("re", 0, 0);
    for (int i = 0; i < N; i++) check("re mem", int'(mem[i]), 32'h20);

    // clr_req wins over a simultaneous byte, which is then held until idle
    put(8'h41);
    wait_ready(10, "pre");
    clear_log();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    clr_req  = 1'b1;
    #1;
    check("clr+v ready", int'(in_ready), 0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    clr_req = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge cpu_clk);
      n++;
    end
    check("held ready", int'(in_ready), 1);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    in_valid = 1'b0;
    wait_ready(10, "held");
    check("held nwr", wr_adrs.size(), N + 1);
    if (wr_adrs.size() == N + 1) begin
      check("held first", wr_data[0], 32'h20);
      check("held adr", wr_adrs[N], 0);
      check("held dat", wr_data[N], 32'h5A);
    end
    check_cursor("held", 1, 0);
    check("bad adrs", bad_adrs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
